// File: rtl/ram_pkg.sv
// Shared constants for the sync_ram_clr storage block: read-during-write
// mode codes, clear-sequencer state encoding and the parity helper.
// Optional feature macro used by the block: SYNC_RAM_PARITY_EN.
package ram_pkg;

  localparam int RDW_WRITE_FIRST = 0;
  localparam int RDW_READ_FIRST  = 1;

  typedef logic [0:0] state_t;

  localparam state_t ST_CLEAR = 1'b0;
  localparam state_t ST_IDLE  = 1'b1;

  // Even parity over a word of up to 64 bits; callers zero-extend narrower data.
  function automatic logic even_parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/ram_clear_fsm.sv
// Clear sequencer for sync_ram_clr: walks the sweep counter over every
// address after reset or on clr_req, and owns the write port while busy.
module ram_clear_fsm
  import ram_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req_i,
  output logic              busy_o,
  output logic [ADDR_W-1:0] sweep_addr_o
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // Next-state logic: sweep one word per cycle, leave CLEAR after the last address.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_IDLE: begin
        if (clr_req_i) begin
          cnt_d   = {ADDR_W{1'b0}};
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = {ADDR_W{1'b0}};
        state_d = ST_CLEAR;
      end
    endcase
  end

  // State and counter registers; reset starts a fresh sweep from address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= {ADDR_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o       = (state_q == ST_CLEAR);
  assign sweep_addr_o = cnt_q;

endmodule

// File: rtl/sync_ram_clr.sv
// Single-port synchronous RAM with registered read data, read-valid strobe
// and a hardware clear sweep that fills every word with INIT_VAL.
// Optional macro SYNC_RAM_PARITY_EN adds a stored even-parity bit per word.
module sync_ram_clr
  import ram_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  parameter int                RDW_MODE = RDW_WRITE_FIRST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              clr_req,
  input  logic              err_inj,
  output logic [DATA_W-1:0] dout,
  output logic              rd_valid,
  output logic              busy,
  output logic              par_err
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef SYNC_RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  logic [MEM_W-1:0]  mem_q [DEPTH];
  logic              busy_s;
  logic [ADDR_W-1:0] sweep_addr_s;
  logic              accept_s;
  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [MEM_W-1:0]  wr_word_s;
  logic [MEM_W-1:0]  user_word_s;
  logic [MEM_W-1:0]  sweep_word_s;
  logic [MEM_W-1:0]  rd_word_s;
  logic              rd_par_err_s;
  logic [DATA_W-1:0] dout_q;
  logic              rd_valid_q;
  logic              par_err_q;

  ram_clear_fsm #(.ADDR_W(ADDR_W)) u_clear_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_req_i    (clr_req),
    .busy_o       (busy_s),
    .sweep_addr_o (sweep_addr_s)
  );

  // While the sweep runs, user accesses are dropped entirely.
  assign accept_s  = cs & ~busy_s;
  assign rd_word_s = mem_q[addr];

`ifdef SYNC_RAM_PARITY_EN
  assign user_word_s  = {even_parity(64'(din)) ^ err_inj, din};
  assign sweep_word_s = {even_parity(64'(INIT_VAL)), INIT_VAL};
  assign rd_par_err_s = even_parity(64'(rd_word_s[DATA_W-1:0])) != rd_word_s[DATA_W];
`else
  logic unused_err_inj_s;
  assign unused_err_inj_s = err_inj;
  assign user_word_s      = din;
  assign sweep_word_s     = INIT_VAL;
  assign rd_par_err_s     = 1'b0;
`endif

  // Write-port mux: the sweep owns the port while busy, otherwise accepted user writes.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = addr;
    wr_word_s = user_word_s;
    if (busy_s) begin
      wr_en_s   = 1'b1;
      wr_addr_s = sweep_addr_s;
      wr_word_s = sweep_word_s;
    end else if (accept_s && we) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Storage array; deliberately not reset, only the sweep initialises it.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_addr_s] <= wr_word_s;
    end
  end

  // Read register: dout updates on every accepted access, rd_valid/par_err pulse on reads only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q     <= {DATA_W{1'b0}};
      rd_valid_q <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      par_err_q  <= 1'b0;
      if (accept_s) begin
        if (we) begin
          if (RDW_MODE == RDW_READ_FIRST) begin
            dout_q <= rd_word_s[DATA_W-1:0];
          end else begin
            dout_q <= din;
          end
        end else begin
          dout_q     <= rd_word_s[DATA_W-1:0];
          rd_valid_q <= 1'b1;
          par_err_q  <= rd_par_err_s;
        end
      end
    end
  end

  assign dout     = dout_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_s;
  assign par_err  = par_err_q;

endmodule

// File: tb/tb_sync_ram_clr.sv
// Self-checking bench for sync_ram_clr: two instances (write-first and
// read-first) share the stimulus; directed vector table plus sweep sequences.
module tb_sync_ram_clr;

  logic       clk;
  logic       rst_n;
  logic       cs;
  logic       we;
  logic [7:0] addr;
  logic [7:0] din;
  logic       clr_req;
  logic       err_inj;
  logic [7:0] dout0, dout1;
  logic       rv0, rv1, busy0, busy1, pe0, pe1;

  int checks = 0;
  int errors = 0;

`ifdef SYNC_RAM_PARITY_EN
  localparam logic EXP_PE7 = 1'b1;
`else
  localparam logic EXP_PE7 = 1'b0;
`endif

  sync_ram_clr #(.DATA_W(8), .ADDR_W(8), .INIT_VAL(8'hA5), .RDW_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .addr(addr), .din(din),
    .clr_req(clr_req), .err_inj(err_inj), .dout(dout0), .rd_valid(rv0),
    .busy(busy0), .par_err(pe0)
  );

  sync_ram_clr #(.DATA_W(8), .ADDR_W(8), .INIT_VAL(8'hA5), .RDW_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .addr(addr), .din(din),
    .clr_req(clr_req), .err_inj(err_inj), .dout(dout1), .rd_valid(rv1),
    .busy(busy1), .par_err(pe1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       cs;
    logic       we;
    logic [7:0] addr;
    logic [7:0] din;
    logic [7:0] exp0;
    logic [7:0] exp1;
    logic       exp_v;
  } vec_t;

  vec_t vecs[10];

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cs      = 1'b0;
    we      = 1'b0;
    clr_req = 1'b0;
    err_inj = 1'b0;
  endtask

  task automatic access(input logic w, input logic [7:0] a, input logic [7:0] d);
    cs   = 1'b1;
    we   = w;
    addr = a;
    din  = d;
    cyc();
    idle_inputs();
  endtask

  // Counts busy cycles until the sweep ends; optional mid-sweep disturbances.
  task automatic count_busy(input bit disturb, output int n);
    n = busy0 ? 1 : 0;
    while (busy0 && n < 1000) begin
      if (disturb && n == 10) clr_req = 1'b1;
      if (disturb && n == 50) begin cs = 1'b1; we = 1'b1; addr = 8'd5; din = 8'h33; end
      if (disturb && n == 51) begin cs = 1'b1; we = 1'b0; addr = 8'd5; end
      cyc();
      if (disturb && (n == 50 || n == 51)) begin
        chk1("busy_rv0", rv0, 1'b0);
        chk1("busy_rv1", rv1, 1'b0);
      end
      idle_inputs();
      if (busy0) n++;
    end
  endtask

  initial begin
    int n;
    logic [7:0] a;

    vecs[0] = '{1'b1, 1'b0, 8'd0,   8'h00, 8'hA5, 8'hA5, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 8'd128, 8'h00, 8'hA5, 8'hA5, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 8'd255, 8'h00, 8'hA5, 8'hA5, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 8'd9,   8'h11, 8'h11, 8'hA5, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 8'd9,   8'h22, 8'h22, 8'h11, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 8'd9,   8'h00, 8'h22, 8'h22, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 8'd9,   8'h00, 8'h22, 8'h22, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 8'd200, 8'h7E, 8'h7E, 8'hA5, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 8'd200, 8'h00, 8'h7E, 8'h7E, 1'b1};
    vecs[9] = '{1'b1, 1'b0, 8'd201, 8'h00, 8'hA5, 8'hA5, 1'b1};

    // Reset state
    rst_n = 1'b0;
    addr  = 8'd0;
    din   = 8'd0;
    idle_inputs();
    #12;
    chk8("rst_dout", dout0, 8'h00);
    chk1("rst_rv", rv0, 1'b0);
    chk1("rst_busy", busy0, 1'b1);
    chk1("rst_pe", pe0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Initial sweep length
    count_busy(1'b0, n);
    chki("init_sweep_len", n, 256);

    // Directed vector table (both read-during-write modes)
    for (int i = 0; i < 10; i++) begin
      cs   = vecs[i].cs;
      we   = vecs[i].we;
      addr = vecs[i].addr;
      din  = vecs[i].din;
      cyc();
      chk8($sformatf("vec%0d_dout0", i), dout0, vecs[i].exp0);
      chk8($sformatf("vec%0d_dout1", i), dout1, vecs[i].exp1);
      chk1($sformatf("vec%0d_rv0", i), rv0, vecs[i].exp_v);
      chk1($sformatf("vec%0d_rv1", i), rv1, vecs[i].exp_v);
    end
    idle_inputs();

    // Full data load: writes never strobe rd_valid
    for (int k = 0; k < 256; k++) begin
      access(1'b1, 8'(k), 8'(k + 10));
      chk1("load_rv", rv0, 1'b0);
    end

    // Random read-back
    for (int r = 0; r < 20; r++) begin
      a = 8'($urandom_range(0, 255));
      access(1'b0, a, 8'h00);
      chk8("rand_dout0", dout0, 8'(a + 8'd10));
      chk8("rand_dout1", dout1, 8'(a + 8'd10));
      chk1("rand_rv", rv0, 1'b1);
    end

    // clr_req with a read in the same cycle: read still performed
    cs = 1'b1; we = 1'b0; addr = 8'd9; clr_req = 1'b1;
    cyc();
    idle_inputs();
    chk1("clr_read_rv", rv0, 1'b1);
    chk8("clr_read_dout", dout0, 8'h13);
    chk1("clr_busy", busy0, 1'b1);

    // Sweep with ignored clr_req and dropped accesses mid-sweep
    count_busy(1'b1, n);
    chki("clr_sweep_len", n, 256);
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? 8'd5 : (i == 1) ? 8'd9 : (i == 2) ? 8'd0 : 8'd255;
      access(1'b0, a, 8'h00);
      chk8("post_clr_dout", dout0, 8'hA5);
      chk1("post_clr_rv", rv0, 1'b1);
    end

    // Reset at sweep cycle 100
    access(1'b1, 8'd20, 8'h5A);
    access(1'b1, 8'd200, 8'h5A);
    access(1'b0, 8'd20, 8'h00);
    chk8("pre_rst_dout", dout0, 8'h5A);
    clr_req = 1'b1;
    cyc();
    idle_inputs();
    for (int c = 1; c < 100; c++) cyc();
    rst_n = 1'b0;
    #1;
    chk8("midrst_dout", dout0, 8'h00);
    chk1("midrst_rv", rv0, 1'b0);
    chk1("midrst_busy", busy0, 1'b1);
    chk1("midrst_pe", pe0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    count_busy(1'b0, n);
    chki("rerun_sweep_len", n, 256);
    access(1'b0, 8'd20, 8'h00);
    chk8("rerun_dout20", dout0, 8'hA5);
    access(1'b0, 8'd200, 8'h00);
    chk8("rerun_dout200", dout0, 8'hA5);

    // Parity injection
    err_inj = 1'b1;
    access(1'b1, 8'd7, 8'h3C);
    access(1'b1, 8'd8, 8'h3C);
    access(1'b0, 8'd7, 8'h00);
    chk8("par7_dout", dout0, 8'h3C);
    chk1("par7_rv", rv0, 1'b1);
    chk1("par7_pe0", pe0, EXP_PE7);
    chk1("par7_pe1", pe1, EXP_PE7);
    access(1'b0, 8'd8, 8'h00);
    chk8("par8_dout", dout0, 8'h3C);
    chk1("par8_pe0", pe0, 1'b0);
    chk1("par8_pe1", pe1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
